spi_mem_sched: RTL and testbench

Command scheduler and memory arbiter between the SPI slave and a single-port synchronous 256x8 RAM. It decodes each 10-bit frame delivered on `rx_data`/`rx_valid` into address-latch, write or read operations. It shares the RAM port round-robin with a local host requester. Read results are returned to the SPI slave on `tx_data`/`tx_valid` for shifting out on MISO.

---
 rtl/spi_mem_sched.sv | 167 ++++++++++++++++
 tb/tb_spi_mem_sched.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_sched.sv
// spi_mem_sched: SPI frame decoder and round-robin RAM arbiter.
// Optional macro SPI_ADDR_AUTOINC_EN: post-increment SPI addresses on grant.
module spi_mem_sched #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] rx_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDRET
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_pend;
  logic              spi_we;
  logic              last_host;
  logic              own_host;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              data_cmd;
  logic              spi_busy;
  logic              arb_spi;
  logic              arb_host;

  assign cmd      = rx_data[DATA_W+1:DATA_W];
  assign payload  = rx_data[DATA_W-1:0];
  assign data_cmd = rx_valid & cmd[0];

  // SPI is busy while a request waits or its access is in flight
  assign spi_busy = spi_pend |
                    ((state != S_IDLE) & ~own_host);

  // Round-robin pick: on a tie the side not granted last wins
  always_comb begin
    arb_spi  = 1'b0;
    arb_host = 1'b0;
    if (state == S_IDLE) begin
      arb_spi  = spi_pend & (~host_req | last_host);
      arb_host = host_req & (~spi_pend | ~last_host);
    end
  end

  // Frame decode: address latches, pending SPI op, overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      spi_wdata <= '0;
      spi_pend  <= 1'b0;
      spi_we    <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_ovf <= data_cmd & spi_busy;
      if (rx_valid && cmd == 2'b00) begin
        wr_addr <= payload;
      end
`ifdef SPI_ADDR_AUTOINC_EN
      else if (arb_spi && spi_we) begin
        wr_addr <= wr_addr + DATA_W'(1);
      end
`endif
      if (rx_valid && cmd == 2'b10) begin
        rd_addr <= payload;
      end
`ifdef SPI_ADDR_AUTOINC_EN
      else if (arb_spi && !spi_we) begin
        rd_addr <= rd_addr + DATA_W'(1);
      end
`endif
      if (arb_spi) begin
        spi_pend <= 1'b0;
      end
      if (data_cmd && !spi_busy) begin
        spi_pend <= 1'b1;
        spi_we   <= ~cmd[1];
        if (!cmd[1]) begin
          spi_wdata <= payload;
        end
      end
    end
  end

  // Access FSM: grant, drive the RAM port, return read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_host   <= 1'b1;
      own_host    <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (arb_spi) begin
            mem_en    <= 1'b1;
            mem_we    <= spi_we;
            mem_addr  <= spi_we ? wr_addr : rd_addr;
            mem_wdata <= spi_we ? spi_wdata : '0;
            own_host  <= 1'b0;
            last_host <= 1'b0;
            state     <= S_ACCESS;
          end else if (arb_host) begin
            mem_en    <= 1'b1;
            mem_we    <= host_we;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            host_gnt  <= 1'b1;
            own_host  <= 1'b1;
            last_host <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          host_gnt <= 1'b0;
          state    <= mem_we ? S_IDLE : S_RDRET;
        end
        S_RDRET: begin
          if (own_host) begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
          end else begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_sched.sv
// tb_spi_mem_sched: scoreboard bench for spi_mem_sched.
// RAM is modelled here; expected accesses and read data are queued.
module tb_spi_mem_sched;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [9:0] rx_data = '0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       err_ovf;

  logic [7:0] ram [256];

  acc_t       exp_acc[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_host[$];
  logic       gnt_log[$];
  acc_t       mon_e;
  logic [7:0] mon_d;

  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int ovf_cnt = 0;

  spi_mem_sched #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        gnt_log.push_back(host_gnt);
        total++;
        if (exp_acc.size() == 0) begin
          bad++;
          $display("FAIL acc_unexpected: got we=%0d addr=%h data=%h, want none",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          mon_e = exp_acc.pop_front();
          if (mem_we !== mon_e.we || mem_addr !== mon_e.addr ||
              (mon_e.we && mem_wdata !== mon_e.data)) begin
            bad++;
            $display("FAIL acc: got we=%0d addr=%h data=%h, want we=%0d addr=%h data=%h",
                     mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.data);
          end
        end
      end
      if (tx_valid) begin
        tx_cnt++;
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got %h, want none", tx_data);
        end else begin
          mon_d = exp_tx.pop_front();
          if (tx_data !== mon_d) begin
            bad++;
            $display("FAIL tx_data: got %h, want %h", tx_data, mon_d);
          end
        end
      end
      if (host_rvalid) begin
        total++;
        if (exp_host.size() == 0) begin
          bad++;
          $display("FAIL host_unexpected: got %h, want none", host_rdata);
        end else begin
          mon_d = exp_host.pop_front();
          if (host_rdata !== mon_d) begin
            bad++;
            $display("FAIL host_rdata: got %h, want %h", host_rdata, mon_d);
          end
        end
      end
      if (err_ovf) ovf_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [7:0] a,
                          input logic [7:0] d);
    acc_t e;
    e.we = we;
    e.addr = a;
    e.data = d;
    exp_acc.push_back(e);
  endtask

  task automatic host_go(input logic we, input logic [7:0] a,
                         input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    host_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (host_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    host_req = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL host_gnt_timeout: got none, want grant");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({tx_valid, tx_data, host_gnt, host_rvalid, host_rdata, mem_en,
         mem_we, mem_addr, mem_wdata, err_ovf} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero, want all 0");
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_arbitration;
    logic [7:0] a;
    logic [7:0] d;
    gnt_log.delete();
    for (int r = 0; r < 2; r++) begin
      a = 8'h20 + 8'(r);
      d = 8'h55 + 8'(r);
      send(2'b00, a);
      idle(3);
      push_acc(1'b1, a, d);
      push_acc(1'b1, 8'h07, 8'h30);
      rx_data  = {2'b01, d};
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      host_go(1'b1, 8'h07, 8'h30);
      idle(4);
    end
    total++;
    if (gnt_log.size() != 4) begin
      bad++;
      $display("FAIL arb_count: got %0d, want 4", gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (gnt_log[i] !== i[0]) begin
          bad++;
          $display("FAIL arb_order[%0d]: got host=%0d, want host=%0d",
                   i, gnt_log[i], i[0]);
        end
      end
    end
  endtask

  task automatic test_write_read;
    send(2'b00, 8'h12);
    idle(4);
    push_acc(1'b1, 8'h12, 8'hA5);
    send(2'b01, 8'hA5);
    @(posedge clk);
    #1;
    total++;
    if (!(mem_en && mem_we) || mem_addr !== 8'h12 || mem_wdata !== 8'hA5) begin
      bad++;
      $display("FAIL wr_cycle2: got en=%0d we=%0d addr=%h data=%h, want 1 1 12 a5",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    idle(4);
    send(2'b10, 8'h12);
    idle(4);
    push_acc(1'b0, 8'h12, 8'h00);
    exp_tx.push_back(8'hA5);
    send(2'b11, 8'h00);
    @(posedge clk);
    #1;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rd_cycle2: got en=%0d we=%0d, want 1 0", mem_en, mem_we);
    end
    @(posedge clk);
    #1;
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_cycle3: got tx_valid=%0d, want 0", tx_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL rd_cycle4: got valid=%0d data=%h, want 1 a5",
               tx_valid, tx_data);
    end
    idle(4);
  endtask

  task automatic test_overrun;
    int ovf0;
    ovf0 = ovf_cnt;
    send(2'b00, 8'h40);
    idle(4);
    push_acc(1'b1, 8'h40, 8'h66);
    send(2'b01, 8'h66);
    send(2'b01, 8'h77);
    total++;
    if (err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pulse: got %0d, want 1", err_ovf);
    end
    idle(6);
    total++;
    if (ovf_cnt - ovf0 != 1) begin
      bad++;
      $display("FAIL ovf_count: got %0d, want 1", ovf_cnt - ovf0);
    end
    send(2'b10, 8'h40);
    idle(4);
    push_acc(1'b0, 8'h40, 8'h00);
    exp_tx.push_back(8'h66);
    send(2'b11, 8'h00);
    idle(6);
  endtask

  task automatic test_host_read;
    push_acc(1'b0, 8'h12, 8'h00);
    exp_host.push_back(8'hA5);
    host_we = 1'b0;
    host_addr = 8'h12;
    host_req = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (host_gnt !== 1'b1 || mem_en !== 1'b1) begin
      bad++;
      $display("FAIL hrd_gnt: got gnt=%0d en=%0d, want 1 1", host_gnt, mem_en);
    end
    host_req = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (host_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL hrd_early: got rvalid=%0d, want 0", host_rvalid);
    end
    @(posedge clk);
    #1;
    total++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL hrd_data: got valid=%0d data=%h, want 1 a5",
               host_rvalid, host_rdata);
    end
    idle(3);
  endtask

  task automatic test_autoinc;
    logic [7:0] a2;
    logic [7:0] rb;
`ifdef SPI_ADDR_AUTOINC_EN
    a2 = 8'h00;
    rb = 8'h11;
`else
    a2 = 8'hFF;
    rb = 8'h22;
`endif
    send(2'b00, 8'hFF);
    idle(4);
    push_acc(1'b1, 8'hFF, 8'h11);
    send(2'b01, 8'h11);
    idle(5);
    push_acc(1'b1, a2, 8'h22);
    send(2'b01, 8'h22);
    idle(5);
    push_acc(1'b0, 8'hFF, 8'h00);
    exp_host.push_back(rb);
    host_go(1'b0, 8'hFF, 8'h00);
    idle(4);
  endtask

  task automatic test_reset_mid_read;
    int tx0;
    send(2'b10, 8'h12);
    idle(4);
    push_acc(1'b0, 8'h12, 8'h00);
    send(2'b11, 8'h00);
    idle(2);
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_valid, tx_data, host_gnt, host_rvalid, host_rdata, mem_en,
         mem_we, mem_addr, mem_wdata, err_ovf} !== 38'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got nonzero, want all 0");
    end
    tx0 = tx_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    total++;
    if (tx_cnt != tx0) begin
      bad++;
      $display("FAIL midrst_tx: got %0d pulses, want 0", tx_cnt - tx0);
    end
    push_acc(1'b1, 8'h00, 8'h99);
    send(2'b01, 8'h99);
    idle(5);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_overrun();
    test_host_read();
    test_autoinc();
    test_reset_mid_read();
    total++;
    if (exp_acc.size() != 0 || exp_tx.size() != 0 || exp_host.size() != 0) begin
      bad++;
      $display("FAIL leftovers: got acc=%0d tx=%0d host=%0d, want 0 0 0",
               exp_acc.size(), exp_tx.size(), exp_host.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
